fetch_unit: RTL and testbench
=============================

# fetch_unit

Byte-stream instruction fetch stage that sits directly upstream of the CPU execution domain and drives its 8-bit `bus_in`. It holds the fetch program counter, issues single-byte read requests to memory over a req/ack handshake, buffers returned bytes in a small prefetch FIFO, and presents them downstream with a valid/ready handshake. A redirect input flushes the buffer and restarts fetching at a new address.

## Interface
- `ADDR_WIDTH`, 64: width of fetch addresses, matching the 64-bit register width.
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `RESET_PC`, 0: fetch address after reset.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `redirect`  in  1  flush the FIFO and restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_WIDTH  new fetch address, sampled when `redirect`=1.
- `mem_req`  out  1  read request, registered.
- `mem_addr`  out  ADDR_WIDTH  request address, stable while `mem_req`=1.
- `mem_ack`  in  1  memory completes the request this cycle; only meaningful while `mem_req`=1.
- `mem_data`  in  8  read byte, valid in the `mem_ack` cycle.
- `bus_out`  out  8  head byte, connects to the domain's `bus_in`.
- `bus_pc`  out  ADDR_WIDTH  address of `bus_out`.
- `bus_valid`  out  1  FIFO non-empty.
- `bus_ready`  in  1  consumer accepts the head byte this cycle.

## Operation
- **State machine:**
  - `IDLE`: no request outstanding; `mem_req`=0.
  - `REQ`: request outstanding; returned data is kept.
  - `DRAIN`: request outstanding; returned data is discarded.
- **FIFO:**
  - Each entry is {byte, address}. `count` is in 0..DEPTH.
  - A pop occurs when `bus_valid` && `bus_ready`.
  - A push occurs on `mem_ack` in `REQ`.
  - Push and pop may occur in the same cycle.
- **Issue rule:** each edge computes `count_next` from this cycle's push/pop. `mem_req` is high next cycle iff `count_next` < DEPTH.
  - The outstanding request reserves one slot, so a push can never overflow.
  - Back-to-back requests are allowed: `mem_req` stays high across an ack with `mem_addr` advanced by 1.
- **Address:**
  - `fetch_pc` increments by 1 on each accepted ack, modulo 2^ADDR_WIDTH. All-ones wraps to 0.
  - `mem_addr` = `fetch_pc`.
- **Transitions (no redirect):**
  - `IDLE`→`REQ` when there is room.
  - `REQ`→`REQ` on ack with room.
  - `REQ`→`IDLE` on ack with no room.
  - `REQ` holds without ack.
- **Redirect:** has priority over push and pop in the same cycle.
  - FIFO is cleared (`count`←0) and `fetch_pc`←`redirect_pc`.
  - In `IDLE`, or in `REQ`/`DRAIN` with `mem_ack`=1: the ack byte (if any) is discarded, and the next state is `REQ` with `mem_addr`=`redirect_pc`.
  - In `REQ`/`DRAIN` with `mem_ack`=0: the request cannot be withdrawn. Next state is `DRAIN` with `mem_addr` unchanged; `fetch_pc` still holds the new address.
- **DRAIN exit:** on `mem_ack`, discard the byte and go to `REQ` at `fetch_pc`. A repeated redirect in `DRAIN` only updates `fetch_pc`.
- **Reset:** asynchronous. It forces `mem_req`=0 immediately and aborts any outstanding request. The memory is reset by the same `reset`.

## Timing
- **Reset values:** `mem_req`=0, `mem_addr`=`RESET_PC`, `bus_out`=0, `bus_pc`=0, `bus_valid`=0, state `IDLE`, `count`=0.
- **After reset:** first edge with `reset` low raises `mem_req` with `mem_addr`=`RESET_PC`.
- **Latency:** ack at edge N → byte visible on `bus_out` with `bus_valid`=1 in cycle N+1.
- **Throughput:** zero-wait memory (`mem_ack` tied 1) with `bus_ready`=1 sustains 1 byte/cycle.
- **FIFO full:** with `bus_ready`=0, exactly DEPTH bytes are fetched, then `mem_req`=0. A single pop reissues `mem_req` next cycle.
- **Redirect:** `bus_valid`=0 the cycle after redirect. The first new byte appears no earlier than 2 cycles after redirect, plus drain time if a request was outstanding.
- **Output paths:** `bus_out`/`bus_pc`/`bus_valid` are driven from FIFO registers, with no combinational path from `mem_*`. `bus_ready` affects only next-state logic.

## Test plan
- **Reset, zero-wait memory:** release `reset`, `mem_ack`=1, `mem_data`=addr[7:0], `bus_ready`=1 → `mem_addr` 0,1,2,…; `bus_out` 00,01,02… on consecutive cycles, first `bus_valid` 2 cycles after release; `bus_pc` matches.
- **Backpressure:** `bus_ready`=0 → exactly 4 acks accepted, `mem_req` drops. Raise `bus_ready` for 1 cycle → pops byte 00, `mem_req` returns next cycle at addr 4.
- **Redirect while idle/full:** FIFO full, `redirect`=1, `redirect_pc`=0x100 → `bus_valid`=0 next cycle; `mem_addr`=0x100; first `bus_pc`=0x100.
- **Redirect with request pending:** memory delays ack 3 cycles on addr 5, redirect to 0x40 in the first wait cycle → ack byte for 5 never appears; next request addr 0x40; `bus_out` = byte at 0x40.
- **Wrap:** `redirect_pc`=all-ones → `bus_pc` sequence FFFF…FF then 0 then 1.
- **Async reset mid-request:** assert `reset` between edges while `mem_req`=1 → `mem_req` and `bus_valid` go to 0 before the next edge; refetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: byte-stream instruction fetch stage.
// Holds the fetch PC, issues one-byte reads over a req/ack handshake,
// buffers returned bytes in a small prefetch FIFO and presents them
// downstream. A redirect flushes the FIFO and restarts fetch at a new PC.
//
// Handshakes:
//   memory side : mem_req is registered and, once raised, stays high with
//                 mem_addr stable until a cycle with mem_ack=1 completes it.
//                 mem_ack/mem_data are ignored while mem_req=0.
//   consumer side: bus_valid/bus_out/bus_pc come straight from FIFO
//                 registers; a byte transfers on every rising edge where
//                 bus_valid && bus_ready. bus_valid never depends on
//                 bus_ready, and bus_ready only feeds next-state logic.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_data,
    output logic [7:0]            bus_out,
    output logic [ADDR_WIDTH-1:0] bus_pc,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [1:0]            dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // DRAIN: a request was in flight when a redirect arrived; its byte is
    // stale and must be swallowed before fetching at the new PC.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;

    logic [7:0]            r_fifo_byte [DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_pc   [DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count_next;
    logic                  w_room;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    // Push/pop decode and next occupancy; redirect overrides both.
    always_comb begin
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_count_next = r_count;
        w_room       = 1'b0;
        w_pc_inc     = r_fetch_pc + ADDR_WIDTH'(1);
        if (redirect) begin
            w_count_next = '0;
        end else begin
            w_push       = (r_state == S_REQ) && mem_ack;
            w_pop        = (r_count != '0) && bus_ready;
            w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
        // A new request is only issued if its byte is guaranteed a slot.
        w_room = (w_count_next < CNT_W'(DEPTH));
    end

    // Request FSM: tracks the outstanding request and the fetch PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_fetch_pc <= RESET_PC;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect) begin
                        r_state    <= S_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= redirect_pc;
                        r_fetch_pc <= redirect_pc;
                    end else if (w_room) begin
                        r_state    <= S_REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                S_REQ: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                        if (mem_ack) begin
                            r_mem_addr <= redirect_pc;
                        end else begin
                            // Request cannot be withdrawn; address stays put.
                            r_state <= S_DRAIN;
                        end
                    end else if (mem_ack) begin
                        r_fetch_pc <= w_pc_inc;
                        r_mem_addr <= w_pc_inc;
                        if (!w_room) begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                        if (mem_ack) begin
                            r_state    <= S_REQ;
                            r_mem_addr <= redirect_pc;
                        end
                    end else if (mem_ack) begin
                        // FIFO was emptied by the redirect, so there is room.
                        r_state    <= S_REQ;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Prefetch FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_byte[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_next;
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_byte[r_wr_ptr] <= mem_data;
                    r_fifo_pc[r_wr_ptr]   <= r_mem_addr;
                    r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign bus_out   = r_fifo_byte[r_rd_ptr];
    assign bus_pc    = r_fifo_pc[r_rd_ptr];
    assign bus_valid = (r_count != '0);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios with hand-computed values.
// Memory returns addr[7:0] as data and acks whenever ack_en is set.
module tb_fetch_unit;

    localparam int AW = 64;

    logic          clk;
    logic          reset;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [7:0]    mem_data;
    logic [7:0]    bus_out;
    logic [AW-1:0] bus_pc;
    logic          bus_valid;
    logic          bus_ready;
    logic [1:0]    dbg_state;

    logic          ack_en;
    int            n_checks;
    int            n_errors;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    fetch_unit #(
        .ADDR_WIDTH (AW),
        .DEPTH      (4),
        .RESET_PC   ('0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .bus_out     (bus_out),
        .bus_pc      (bus_pc),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .dbg_state   (dbg_state)
    );

    // Simple memory model
    assign mem_ack  = ack_en & mem_req;
    assign mem_data = mem_addr[7:0];

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with quiet inputs; leaves reset asserted
    task automatic do_reset();
        reset       = 1'b1;
        ack_en      = 1'b0;
        redirect    = 1'b0;
        bus_ready   = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        tick();
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req);
        end
        n_checks++;
        if (mem_addr !== 64'h0) begin
            n_errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr);
        end
        n_checks++;
        if (bus_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_bus_valid: got %b expected 0", bus_valid);
        end
        n_checks++;
        if (bus_out !== 8'h00 || bus_pc !== 64'h0) begin
            n_errors++; $display("FAIL reset_bus: got %h/%h expected 00/0", bus_out, bus_pc);
        end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin
            n_errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_zero_wait();
        ack_en    = 1'b1;
        bus_ready = 1'b1;
        reset     = 1'b0;
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h0 || bus_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL zw_first_req: got req=%b addr=%h valid=%b expected 1/0/0",
                     mem_req, mem_addr, bus_valid);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (bus_valid !== 1'b1 || bus_out !== 8'(i) || bus_pc !== 64'(i)
                || mem_addr !== 64'(i + 1)) begin
                n_errors++;
                $display("FAIL zw_stream_%0d: got v=%b out=%h pc=%h addr=%h expected 1/%h/%h/%h",
                         i, bus_valid, bus_out, bus_pc, mem_addr, 8'(i), 64'(i), 64'(i + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ack_en    = 1'b1;
        bus_ready = 1'b0;
        reset     = 1'b0;
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h0) begin
            n_errors++; $display("FAIL bp_first: got req=%b addr=%h expected 1/0", mem_req, mem_addr);
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 64'(k) || bus_out !== 8'h00 || bus_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_fill_%0d: got req=%b addr=%h out=%h v=%b expected 1/%0d/00/1",
                         k, mem_req, mem_addr, bus_out, bus_valid, k);
            end
        end
        tick();
        n_checks++;
        if (mem_req !== 1'b0 || dbg_state !== ST_IDLE || bus_out !== 8'h00) begin
            n_errors++;
            $display("FAIL bp_full: got req=%b st=%0d out=%h expected 0/0/00", mem_req, dbg_state, bus_out);
        end
        tick();
        n_checks++;
        if (mem_req !== 1'b0 || bus_valid !== 1'b1 || bus_pc !== 64'h0) begin
            n_errors++;
            $display("FAIL bp_hold: got req=%b v=%b pc=%h expected 0/1/0", mem_req, bus_valid, bus_pc);
        end
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h4 || bus_out !== 8'h01 || bus_pc !== 64'h1) begin
            n_errors++;
            $display("FAIL bp_reissue: got req=%b addr=%h out=%h pc=%h expected 1/4/01/1",
                     mem_req, mem_addr, bus_out, bus_pc);
        end
        tick();
        n_checks++;
        if (mem_req !== 1'b0 || bus_out !== 8'h01) begin
            n_errors++; $display("FAIL bp_refull: got req=%b out=%h expected 0/01", mem_req, bus_out);
        end
    endtask

    // Continues from the full FIFO left by test_backpressure
    task automatic test_redirect_full();
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        tick();
        redirect  = 1'b0;
        bus_ready = 1'b1;
        n_checks++;
        if (bus_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 64'h100) begin
            n_errors++;
            $display("FAIL rf_flush: got v=%b req=%b addr=%h expected 0/1/100", bus_valid, mem_req, mem_addr);
        end
        tick();
        n_checks++;
        if (bus_valid !== 1'b1 || bus_pc !== 64'h100 || bus_out !== 8'h00 || mem_addr !== 64'h101) begin
            n_errors++;
            $display("FAIL rf_first: got v=%b pc=%h out=%h addr=%h expected 1/100/00/101",
                     bus_valid, bus_pc, bus_out, mem_addr);
        end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        ack_en    = 1'b1;
        bus_ready = 1'b1;
        reset     = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (mem_addr !== 64'h5 || bus_out !== 8'h04) begin
            n_errors++; $display("FAIL rp_setup: got addr=%h out=%h expected 5/04", mem_addr, bus_out);
        end
        ack_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (bus_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 64'h5 || dbg_state !== ST_DRAIN) begin
            n_errors++;
            $display("FAIL rp_drain: got v=%b req=%b addr=%h st=%0d expected 0/1/5/2",
                     bus_valid, mem_req, mem_addr, dbg_state);
        end
        tick();
        n_checks++;
        if (bus_valid !== 1'b0 || dbg_state !== ST_DRAIN) begin
            n_errors++; $display("FAIL rp_wait: got v=%b st=%0d expected 0/2", bus_valid, dbg_state);
        end
        ack_en = 1'b1;
        tick();
        n_checks++;
        if (bus_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 64'h40 || dbg_state !== ST_REQ) begin
            n_errors++;
            $display("FAIL rp_discard: got v=%b req=%b addr=%h st=%0d expected 0/1/40/1",
                     bus_valid, mem_req, mem_addr, dbg_state);
        end
        tick();
        n_checks++;
        if (bus_valid !== 1'b1 || bus_out !== 8'h40 || bus_pc !== 64'h40) begin
            n_errors++;
            $display("FAIL rp_newbyte: got v=%b out=%h pc=%h expected 1/40/40", bus_valid, bus_out, bus_pc);
        end
    endtask

    // Continues streaming from test_redirect_pending; redirect lands with an ack
    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = {AW{1'b1}};
        tick();
        redirect = 1'b0;
        n_checks++;
        if (mem_addr !== {AW{1'b1}} || bus_valid !== 1'b0) begin
            n_errors++; $display("FAIL wrap_redirect: got addr=%h v=%b expected all-ones/0", mem_addr, bus_valid);
        end
        tick();
        n_checks++;
        if (bus_pc !== {AW{1'b1}} || bus_out !== 8'hFF || mem_addr !== 64'h0) begin
            n_errors++;
            $display("FAIL wrap_top: got pc=%h out=%h addr=%h expected all-ones/ff/0", bus_pc, bus_out, mem_addr);
        end
        tick();
        n_checks++;
        if (bus_pc !== 64'h0 || bus_out !== 8'h00 || bus_valid !== 1'b1) begin
            n_errors++; $display("FAIL wrap_zero: got pc=%h out=%h v=%b expected 0/00/1", bus_pc, bus_out, bus_valid);
        end
        tick();
        n_checks++;
        if (bus_pc !== 64'h1 || bus_out !== 8'h01) begin
            n_errors++; $display("FAIL wrap_one: got pc=%h out=%h expected 1/01", bus_pc, bus_out);
        end
    endtask

    task automatic test_async_reset();
        n_checks++;
        if (mem_req !== 1'b1 || bus_valid !== 1'b1) begin
            n_errors++; $display("FAIL ar_setup: got req=%b v=%b expected 1/1", mem_req, bus_valid);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || bus_valid !== 1'b0 || mem_addr !== 64'h0 || dbg_state !== ST_IDLE) begin
            n_errors++;
            $display("FAIL ar_immediate: got req=%b v=%b addr=%h st=%0d expected 0/0/0/0",
                     mem_req, bus_valid, mem_addr, dbg_state);
        end
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h0 || bus_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ar_refetch: got req=%b addr=%h v=%b expected 1/0/0", mem_req, mem_addr, bus_valid);
        end
        tick();
        n_checks++;
        if (bus_valid !== 1'b1 || bus_pc !== 64'h0 || bus_out !== 8'h00) begin
            n_errors++;
            $display("FAIL ar_first: got v=%b pc=%h out=%h expected 1/0/00", bus_valid, bus_pc, bus_out);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        bus_ready   = 1'b0;
        ack_en      = 1'b0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_full();
        test_redirect_pending();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
